// File: rtl/fir_axil_cfg_slave.sv
// ---------------------------------------------------------------------------
// fir_axil_cfg_slave
//
// AXI4-Lite responder for the FIR configuration space. Holds ap_ctrl
// (idle/done/start), the tap count and the data length, and maps tap
// coefficients onto the external tap BRAM. While a run is active (idle=0)
// the tap BRAM port belongs to the FIR core; the AXI side can neither read
// nor write taps during that time.
//
// Address map (region = addr[31:28]):
//   0x0  ap_ctrl  {bit2 idle, bit1 done, bit0 start}
//   0x1  tap_num
//   0x2  data_len
//   0x3  tap[k], k = addr[TAP_NUM_WIDTH-1:0]
//   else writes dropped, reads return 0
//
// Handshake rules: a write is taken when awvalid and wvalid are both high in
// IDLE (write wins over a simultaneous arvalid); awready/wready are then high
// together for exactly one cycle. A read raises arready for one cycle, then
// rvalid two cycles later (arvalid -> rvalid = 3 cycles); rvalid and rdata
// hold until rready is seen high on a clock edge.
//
// Ports:
//   aclk, areset                      clock, synchronous active-high reset
//   in_s_aw*/in_s_w*/out_s_awready/
//   out_s_wready                      AXI-Lite write address/data channels
//   in_s_ar*/out_s_arready/out_s_rvalid/
//   in_s_rready/out_s_rdata           AXI-Lite read address/data channels
//   out_tap_WE/EN/A/Di, in_tap_Do     tap BRAM port (1-cycle read latency)
//   in_core_tap_EN/A                  core tap read request (used while busy)
//   in_core_done                      core pulse: run finished
//   out_ap_start                      one-cycle start pulse to the core
//   out_tap_num, out_data_len         configuration registers
//   dbg_state                         current FSM state
// ---------------------------------------------------------------------------
module fir_axil_cfg_slave #(
   parameter int pADDR_WIDTH   = 32,
   parameter int pDATA_WIDTH   = 32,
   parameter int TAP_NUM_WIDTH = 10
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       in_s_awvalid,
   input  logic [pADDR_WIDTH-1:0]     in_s_awaddr,
   output logic                       out_s_awready,
   input  logic                       in_s_wvalid,
   input  logic [pDATA_WIDTH-1:0]     in_s_wdata,
   output logic                       out_s_wready,
   input  logic                       in_s_arvalid,
   input  logic [pADDR_WIDTH-1:0]     in_s_araddr,
   output logic                       out_s_arready,
   output logic                       out_s_rvalid,
   input  logic                       in_s_rready,
   output logic [pDATA_WIDTH-1:0]     out_s_rdata,
   output logic [pDATA_WIDTH/8-1:0]   out_tap_WE,
   output logic                       out_tap_EN,
   output logic [TAP_NUM_WIDTH-1:0]   out_tap_A,
   output logic [pDATA_WIDTH-1:0]     out_tap_Di,
   input  logic [pDATA_WIDTH-1:0]     in_tap_Do,
   input  logic                       in_core_tap_EN,
   input  logic [TAP_NUM_WIDTH-1:0]   in_core_tap_A,
   input  logic                       in_core_done,
   output logic                       out_ap_start,
   output logic [pDATA_WIDTH-1:0]     out_tap_num,
   output logic [pDATA_WIDTH-1:0]     out_data_len,
   output logic [2:0]                 dbg_state
);

   localparam int WE_WIDTH = pDATA_WIDTH / 8;

   localparam logic [3:0] REG_CTRL     = 4'h0;
   localparam logic [3:0] REG_TAP_NUM  = 4'h1;
   localparam logic [3:0] REG_DATA_LEN = 4'h2;
   localparam logic [3:0] REG_TAP      = 4'h3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_RD_RAM  = 3'd2,
      S_RD_WAIT = 3'd3,
      S_RD_RESP = 3'd4
   } state_t;

   state_t state_q, state_d;

   // control / configuration state
   logic                     ap_start_q;
   logic                     ap_done_q;
   logic                     ap_idle_q;
   logic [pDATA_WIDTH-1:0]   tap_num_q;
   logic [pDATA_WIDTH-1:0]   data_len_q;

   // read path state
   logic [3:0]               rd_region_q;
   logic                     rd_tap_ok_q;   // tap read was allowed to touch the BRAM
   logic [pDATA_WIDTH-1:0]   rdata_q;

   // FSM-side tap port request, before the ownership mux
   logic                     fsm_tap_en;
   logic [WE_WIDTH-1:0]      fsm_tap_we;
   logic [TAP_NUM_WIDTH-1:0] fsm_tap_a;
   logic [pDATA_WIDTH-1:0]   fsm_tap_di;

   logic [3:0]               wr_region;
   logic [3:0]               rd_region;
   logic                     wr_fire;
   logic                     rd_done;
   logic [pDATA_WIDTH-1:0]   ctrl_word;

   assign wr_region = in_s_awaddr[pADDR_WIDTH-1 -: 4];
   assign rd_region = in_s_araddr[pADDR_WIDTH-1 -: 4];
   assign wr_fire   = (state_q == S_WR);
   assign rd_done   = (state_q == S_RD_RESP) && in_s_rready;
   assign ctrl_word = {{(pDATA_WIDTH-3){1'b0}}, ap_idle_q, ap_done_q, ap_start_q};

   // address bits between the tap index and the region select are ignored
   logic unused_addr_bits;
   assign unused_addr_bits = ^{in_s_awaddr[pADDR_WIDTH-5:TAP_NUM_WIDTH],
                               in_s_araddr[pADDR_WIDTH-5:TAP_NUM_WIDTH]};

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (in_s_awvalid && in_s_wvalid) state_d = S_WR;
            else if (in_s_arvalid)           state_d = S_RD_RAM;
         end
         S_WR:      state_d = S_IDLE;
         S_RD_RAM:  state_d = S_RD_WAIT;
         S_RD_WAIT: state_d = S_RD_RESP;
         S_RD_RESP: if (in_s_rready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      out_s_awready = 1'b0;
      out_s_wready  = 1'b0;
      out_s_arready = 1'b0;
      out_s_rvalid  = 1'b0;
      fsm_tap_en    = 1'b0;
      fsm_tap_we    = '0;
      fsm_tap_a     = '0;
      fsm_tap_di    = '0;
      case (state_q)
         S_WR: begin
            out_s_awready = 1'b1;
            out_s_wready  = 1'b1;
            // tap writes go straight to the BRAM in the handshake cycle
            if (wr_region == REG_TAP && ap_idle_q) begin
               fsm_tap_en = 1'b1;
               fsm_tap_we = '1;
               fsm_tap_a  = in_s_awaddr[TAP_NUM_WIDTH-1:0];
               fsm_tap_di = in_s_wdata;
            end
         end
         S_RD_RAM: begin
            out_s_arready = 1'b1;
            // araddr is still held this cycle, so it can address the BRAM directly
            if (rd_region == REG_TAP && ap_idle_q) begin
               fsm_tap_en = 1'b1;
               fsm_tap_a  = in_s_araddr[TAP_NUM_WIDTH-1:0];
            end
         end
         S_RD_RESP: out_s_rvalid = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Tap BRAM ownership: the core owns the port for the whole run
   // ------------------------------------------------------------------
   always_comb begin
      if (!ap_idle_q) begin
         out_tap_EN = in_core_tap_EN;
         out_tap_A  = in_core_tap_A;
         out_tap_WE = '0;
         out_tap_Di = '0;
      end else begin
         out_tap_EN = fsm_tap_en;
         out_tap_A  = fsm_tap_a;
         out_tap_WE = fsm_tap_we;
         out_tap_Di = fsm_tap_di;
      end
   end

   // ------------------------------------------------------------------
   // ap_ctrl: start pulse, done (read-to-clear), idle
   // Later assignments win: a core_done in the same cycle as the
   // read-to-clear leaves done set.
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         ap_start_q <= 1'b0;
         ap_done_q  <= 1'b0;
         ap_idle_q  <= 1'b1;
      end else begin
         ap_start_q <= 1'b0;
         if (wr_fire && wr_region == REG_CTRL && in_s_wdata[0] && ap_idle_q) begin
            ap_start_q <= 1'b1;
            ap_idle_q  <= 1'b0;
            ap_done_q  <= 1'b0;
         end
         if (rd_done && rd_region_q == REG_CTRL) begin
            ap_done_q <= 1'b0;
         end
         if (in_core_done) begin
            ap_done_q <= 1'b1;
            ap_idle_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Configuration registers: frozen while a run is active
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         tap_num_q  <= '0;
         data_len_q <= '0;
      end else if (wr_fire && ap_idle_q) begin
         if (wr_region == REG_TAP_NUM)  tap_num_q  <= in_s_wdata;
         if (wr_region == REG_DATA_LEN) data_len_q <= in_s_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Read path: latch the region in RD_RAM, capture data in RD_WAIT,
   // hold it through RD_RESP
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         rd_region_q <= '0;
         rd_tap_ok_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         if (state_q == S_RD_RAM) begin
            rd_region_q <= rd_region;
            rd_tap_ok_q <= ap_idle_q;
         end
         if (state_q == S_RD_WAIT) begin
            case (rd_region_q)
               REG_CTRL:     rdata_q <= ctrl_word;
               REG_TAP_NUM:  rdata_q <= tap_num_q;
               REG_DATA_LEN: rdata_q <= data_len_q;
               REG_TAP:      rdata_q <= rd_tap_ok_q ? in_tap_Do : '0;
               default:      rdata_q <= '0;
            endcase
         end
      end
   end

   assign out_s_rdata  = rdata_q;
   assign out_ap_start = ap_start_q;
   assign out_tap_num  = tap_num_q;
   assign out_data_len = data_len_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_fir_axil_cfg_slave.sv
// ---------------------------------------------------------------------------
// tb_fir_axil_cfg_slave
//
// Bench for the FIR AXI-Lite configuration slave. Contains a tap BRAM with
// one-cycle read latency, a register-level model of the configuration space
// and a scoreboard of expected read data.
// ---------------------------------------------------------------------------
module tb_fir_axil_cfg_slave;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TW = 10;

   // ---------------- clock / reset ----------------
   logic aclk = 1'b0;
   logic areset;
   always #5 aclk = ~aclk;

   logic            in_s_awvalid, in_s_wvalid, in_s_arvalid, in_s_rready;
   logic [AW-1:0]   in_s_awaddr, in_s_araddr;
   logic [DW-1:0]   in_s_wdata;
   logic            out_s_awready, out_s_wready, out_s_arready, out_s_rvalid;
   logic [DW-1:0]   out_s_rdata;
   logic [DW/8-1:0] out_tap_WE;
   logic            out_tap_EN;
   logic [TW-1:0]   out_tap_A;
   logic [DW-1:0]   out_tap_Di;
   logic [DW-1:0]   in_tap_Do;
   logic            in_core_tap_EN;
   logic [TW-1:0]   in_core_tap_A;
   logic            in_core_done;
   logic            out_ap_start;
   logic [DW-1:0]   out_tap_num, out_data_len;
   logic [2:0]      dbg_state;

   fir_axil_cfg_slave #(
      .pADDR_WIDTH  (AW),
      .pDATA_WIDTH  (DW),
      .TAP_NUM_WIDTH(TW)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .in_s_awvalid  (in_s_awvalid),
      .in_s_awaddr   (in_s_awaddr),
      .out_s_awready (out_s_awready),
      .in_s_wvalid   (in_s_wvalid),
      .in_s_wdata    (in_s_wdata),
      .out_s_wready  (out_s_wready),
      .in_s_arvalid  (in_s_arvalid),
      .in_s_araddr   (in_s_araddr),
      .out_s_arready (out_s_arready),
      .out_s_rvalid  (out_s_rvalid),
      .in_s_rready   (in_s_rready),
      .out_s_rdata   (out_s_rdata),
      .out_tap_WE    (out_tap_WE),
      .out_tap_EN    (out_tap_EN),
      .out_tap_A     (out_tap_A),
      .out_tap_Di    (out_tap_Di),
      .in_tap_Do     (in_tap_Do),
      .in_core_tap_EN(in_core_tap_EN),
      .in_core_tap_A (in_core_tap_A),
      .in_core_done  (in_core_done),
      .out_ap_start  (out_ap_start),
      .out_tap_num   (out_tap_num),
      .out_data_len  (out_data_len),
      .dbg_state     (dbg_state)
   );

   // ---------------- tap BRAM (byte writes, read-first, 1-cycle latency) ----
   logic [DW-1:0] bram [0:(1<<TW)-1];
   always @(posedge aclk) begin
      if (out_tap_EN) begin
         for (int b = 0; b < DW/8; b++)
            if (out_tap_WE[b]) bram[out_tap_A][8*b +: 8] <= out_tap_Di[8*b +: 8];
         in_tap_Do <= bram[out_tap_A];
      end
   end

   // ---------------- reference model / scoreboard ----------------
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];

   logic [DW-1:0] m_tap [0:(1<<TW)-1];
   logic [DW-1:0] m_tap_num, m_data_len;
   bit            m_idle, m_done;

   function automatic void model_reset();
      m_tap_num  = '0;
      m_data_len = '0;
      m_idle     = 1'b1;
      m_done     = 1'b0;
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
      case (addr[31:28])
         4'h0:    return {29'd0, m_idle, m_done, 1'b0};
         4'h1:    return m_tap_num;
         4'h2:    return m_data_len;
         4'h3:    return m_idle ? m_tap[addr[TW-1:0]] : '0;
         default: return '0;
      endcase
   endfunction

   function automatic void model_after_read(input logic [AW-1:0] addr);
      if (addr[31:28] == 4'h0) m_done = 1'b0;
   endfunction

   function automatic void model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      case (addr[31:28])
         4'h0: if (data[0] && m_idle) begin m_idle = 1'b0; m_done = 1'b0; end
         4'h1: if (m_idle) m_tap_num = data;
         4'h2: if (m_idle) m_data_len = data;
         4'h3: if (m_idle) m_tap[addr[TW-1:0]] = data;
         default: ;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            output logic start_seen);
      int cyc = 0;
      @(negedge aclk);
      in_s_awvalid = 1'b1; in_s_wvalid = 1'b1;
      in_s_awaddr  = addr; in_s_wdata  = data;
      do begin @(negedge aclk); cyc++; end while (!out_s_wready && cyc < 10);
      n_checks++;
      if ({out_s_awready, out_s_wready} !== 2'b11 || cyc != 1) begin
         n_fail++;
         $display("FAIL write_handshake addr=%h: awready/wready=%b%b after %0d cycles, required 11 after 1",
                  addr, out_s_awready, out_s_wready, cyc);
      end
      model_write(addr, data);
      @(negedge aclk);
      in_s_awvalid = 1'b0; in_s_wvalid = 1'b0;
      start_seen = out_ap_start;
      n_checks++;
      if (out_s_wready !== 1'b0) begin
         n_fail++;
         $display("FAIL wready_one_cycle addr=%h: wready=%b, required 0", addr, out_s_wready);
      end
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, input int hold, output logic [DW-1:0] data);
      int cyc = 0;
      bit seen_ar = 0;
      logic [DW-1:0] e;
      exp_q.push_back(model_read(addr));
      @(negedge aclk);
      in_s_arvalid = 1'b1; in_s_araddr = addr; in_s_rready = (hold == 0);
      while (!out_s_rvalid && cyc < 20) begin
         @(negedge aclk); cyc++;
         if (seen_ar) in_s_arvalid = 1'b0;
         if (out_s_arready) seen_ar = 1;
      end
      in_s_arvalid = 1'b0;
      n_checks++;
      if (out_s_rvalid !== 1'b1 || cyc != 3) begin
         n_fail++;
         $display("FAIL read_latency addr=%h: rvalid=%b after %0d cycles, required 1 after 3",
                  addr, out_s_rvalid, cyc);
      end
      data = out_s_rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge aclk);
         n_checks++;
         if (out_s_rvalid !== 1'b1 || out_s_rdata !== data) begin
            n_fail++;
            $display("FAIL read_hold addr=%h: rvalid=%b rdata=%h, required 1 %h",
                     addr, out_s_rvalid, out_s_rdata, data);
         end
      end
      in_s_rready = 1'b1;
      @(negedge aclk);
      n_checks++;
      if (out_s_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL read_release addr=%h: rvalid=%b, required 0", addr, out_s_rvalid);
      end
      in_s_rready = 1'b0;
      model_after_read(addr);
      e = exp_q.pop_front();
      n_checks++;
      if (data !== e) begin
         n_fail++;
         $display("FAIL read_data addr=%h: got %h, required %h", addr, data, e);
      end
   endtask

   task automatic pulse_core_done();
      @(negedge aclk); in_core_done = 1'b1;
      @(negedge aclk); in_core_done = 1'b0;
      m_done = 1'b1; m_idle = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [DW-1:0] d;
      areset = 1'b1;
      @(negedge aclk);
      in_s_awvalid = 1'b1; in_s_wvalid = 1'b1; in_s_arvalid = 1'b1; in_s_rready = 1'b1;
      repeat (3) begin
         @(negedge aclk);
         n_checks++;
         if ({out_s_awready, out_s_wready, out_s_arready, out_s_rvalid, out_ap_start, out_tap_EN} !== 6'b0 ||
             out_tap_WE !== '0 || out_s_rdata !== '0 || out_tap_num !== '0 || out_data_len !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: aw/w/ar/rv/start/en=%b%b%b%b%b%b we=%h rdata=%h, required all 0",
                     out_s_awready, out_s_wready, out_s_arready, out_s_rvalid, out_ap_start,
                     out_tap_EN, out_tap_WE, out_s_rdata);
         end
      end
      in_s_awvalid = 1'b0; in_s_wvalid = 1'b0; in_s_arvalid = 1'b0; in_s_rready = 1'b0;
      areset = 1'b0;
      model_reset();
      axi_read(32'h0000_0000, 0, d);
   endtask

   task automatic test_regs();
      logic s;
      logic [DW-1:0] d;
      axi_write(32'h1000_0000, 32'd11, s);
      axi_write(32'h2000_0000, 32'd600, s);
      axi_read(32'h1000_0000, 0, d);
      axi_read(32'h2000_0000, 0, d);
      n_checks++;
      if (out_tap_num !== 32'd11 || out_data_len !== 32'd600) begin
         n_fail++;
         $display("FAIL cfg_outputs: tap_num=%0d data_len=%0d, required 11 600", out_tap_num, out_data_len);
      end
   endtask

   task automatic test_taps();
      int tap_vals[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
      logic s;
      logic [DW-1:0] d;
      for (int k = 0; k < 11; k++) axi_write(32'h3000_0000 + k, tap_vals[k], s);
      for (int k = 0; k < 11; k++) axi_read(32'h3000_0000 + k, 0, d);
   endtask

   task automatic test_start_busy();
      logic s;
      logic [DW-1:0] d;
      axi_write(32'h0000_0000, 32'h1, s);
      n_checks++;
      if (s !== 1'b1) begin
         n_fail++;
         $display("FAIL ap_start_pulse: ap_start=%b, required 1", s);
      end
      @(negedge aclk);
      n_checks++;
      if (out_ap_start !== 1'b0) begin
         n_fail++;
         $display("FAIL ap_start_width: ap_start=%b, required 0", out_ap_start);
      end
      axi_read(32'h0000_0000, 0, d);            // idle=0
      in_core_tap_EN = 1'b1; in_core_tap_A = 10'd5;
      @(negedge aclk);
      n_checks++;
      if (out_tap_EN !== 1'b1 || out_tap_A !== 10'd5 || out_tap_WE !== '0) begin
         n_fail++;
         $display("FAIL core_tap_mux: EN=%b A=%0d WE=%h, required 1 5 0", out_tap_EN, out_tap_A, out_tap_WE);
      end
      in_core_tap_EN = 1'b0; in_core_tap_A = '0;
      axi_write(32'h3000_0003, 32'd99, s);      // dropped while busy
      axi_write(32'h1000_0000, 32'd77, s);      // dropped while busy
      axi_write(32'h0000_0000, 32'h1, s);       // start ignored while busy
      n_checks++;
      if (s !== 1'b0) begin
         n_fail++;
         $display("FAIL start_while_busy: ap_start=%b, required 0", s);
      end
      axi_read(32'h3000_0003, 0, d);            // busy tap read -> 0
      pulse_core_done();
      axi_read(32'h0000_0000, 5, d);            // 0x6, held 5 cycles
      axi_read(32'h0000_0000, 0, d);            // 0x4
      axi_read(32'h3000_0003, 0, d);            // still 23
      axi_read(32'h1000_0000, 0, d);            // still 11
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] v = $urandom;
      logic [DW-1:0] d = '0;
      int w_cyc = 0, r_cyc = 0;
      bit w_seen = 0, ar_seen = 0;
      @(negedge aclk);
      in_s_awvalid = 1'b1; in_s_wvalid = 1'b1; in_s_awaddr = 32'h2000_0000; in_s_wdata = v;
      in_s_arvalid = 1'b1; in_s_araddr = 32'h2000_0000; in_s_rready = 1'b1;
      for (int cyc = 1; cyc <= 15 && r_cyc == 0; cyc++) begin
         @(negedge aclk);
         if (w_seen)  begin in_s_awvalid = 1'b0; in_s_wvalid = 1'b0; end
         if (ar_seen) in_s_arvalid = 1'b0;
         if (out_s_wready && w_cyc == 0) begin w_cyc = cyc; w_seen = 1; end
         if (out_s_arready) ar_seen = 1;
         if (out_s_rvalid) begin r_cyc = cyc; d = out_s_rdata; end
      end
      model_write(32'h2000_0000, v);
      @(negedge aclk);
      in_s_awvalid = 1'b0; in_s_wvalid = 1'b0; in_s_arvalid = 1'b0; in_s_rready = 1'b0;
      n_checks++;
      if (w_cyc == 0 || r_cyc <= w_cyc) begin
         n_fail++;
         $display("FAIL simul_order: write at cycle %0d, read at cycle %0d, required write first", w_cyc, r_cyc);
      end
      n_checks++;
      if (d !== m_data_len) begin
         n_fail++;
         $display("FAIL simul_data: got %h, required %h", d, m_data_len);
      end
   endtask

   task automatic test_random();
      logic s, exp_s;
      logic [DW-1:0] d, v;
      logic [AW-1:0] a;
      for (int it = 0; it < 60; it++) begin
         v = $urandom;
         case ($urandom_range(0, 5))
            0: axi_write({4'h3, 18'd0, 10'($urandom_range(0, 10))}, v, s);
            1: axi_write({4'($urandom_range(1, 2)), 28'd0}, v, s);
            2: begin
               a = {4'($urandom_range(0, 15)), 18'd0, 10'($urandom_range(0, 10))};
               axi_read(a, $urandom_range(0, 3), d);
            end
            3: axi_write({4'($urandom_range(4, 15)), 28'($urandom)}, v, s);
            4: begin
               exp_s = v[0] & m_idle;
               axi_write(32'h0000_0000, v, s);
               n_checks++;
               if (s !== exp_s) begin
                  n_fail++;
                  $display("FAIL rand_start it=%0d: ap_start=%b, required %b", it, s, exp_s);
               end
            end
            default: if (!m_idle) pulse_core_done();
         endcase
      end
   endtask

   task automatic test_reset_mid();
      logic s;
      logic [DW-1:0] d;
      int cyc = 0;
      axi_write(32'h1000_0000, 32'd42, s);
      @(negedge aclk);
      in_s_arvalid = 1'b1; in_s_araddr = 32'h1000_0000; in_s_rready = 1'b0;
      while (!out_s_rvalid && cyc < 20) begin @(negedge aclk); cyc++; end
      in_s_arvalid = 1'b0;
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      model_reset();
      n_checks++;
      if (out_s_rvalid !== 1'b0 || out_tap_num !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: rvalid=%b tap_num=%0d, required 0 0", out_s_rvalid, out_tap_num);
      end
      axi_read(32'h0000_0000, 0, d);
      axi_read(32'h3000_0005, 0, d);            // BRAM contents survive reset
      axi_read(32'h1000_0000, 0, d);
   endtask

   // ---------------- sequence ----------------
   initial begin
      areset = 1'b1;
      in_s_awvalid = 1'b0; in_s_wvalid = 1'b0; in_s_arvalid = 1'b0; in_s_rready = 1'b0;
      in_s_awaddr = '0; in_s_araddr = '0; in_s_wdata = '0;
      in_core_tap_EN = 1'b0; in_core_tap_A = '0; in_core_done = 1'b0;
      model_reset();
      test_reset();
      test_regs();
      test_taps();
      test_start_busy();
      test_simultaneous();
      test_random();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
